// File: rtl/otter_lsu_if.sv
// Bundle of the LSU's request/response handshake and the memory data port.
// The slave view belongs to the LSU. The master view belongs to its environment,
// which is the execute stage on the request side and the memory on port 2.
`timescale 1ns/1ps

interface otter_lsu_if;
    // request from execute stage
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    // response to execute stage
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_io;
    // memory data port (port 2)
    logic        MEM_RDEN2;
    logic        MEM_WE2;
    logic [31:0] MEM_ADDR2;
    logic [31:0] MEM_DIN2;
    logic [1:0]  MEM_SIZE;
    logic        MEM_SIGN;
    logic [31:0] MEM_DOUT2;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, MEM_DOUT2,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_io,
               MEM_RDEN2, MEM_WE2, MEM_ADDR2, MEM_DIN2, MEM_SIZE, MEM_SIGN
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, MEM_DOUT2,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_io,
               MEM_RDEN2, MEM_WE2, MEM_ADDR2, MEM_DIN2, MEM_SIZE, MEM_SIGN
    );
endinterface

// File: rtl/otter_lsu.sv
// OTTER RV32I load/store unit: one request at a time, drives memory port 2,
// returns sized/extended load data or store completion over valid/ready.
`timescale 1ns/1ps

module otter_lsu #(
    parameter logic [31:0] MMIO_BASE   = 32'h00010000,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input logic      CLK,
    input logic      RST,
    otter_lsu_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [31:0] addr_p0;
    logic [31:0] wdata_p0;
    logic        we_p0;
    logic [2:0]  funct3_p0;
    logic        err_p0;
    logic [31:0] rdata_p1;
    logic        req_err;
    logic        accept;

    // Illegal funct3, store with the unsigned bit set, or (optionally) a
    // misaligned half/word. Halves at offsets 0..2 stay legal because the
    // memory can return them from a single word.
    function automatic logic req_illegal(input logic we, input logic [2:0] f3,
                                         input logic [1:0] off);
        logic bad;
        bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        if (we && f3[2])
            bad = 1'b1;
        if (CHECK_ALIGN) begin
            if ((f3[1:0] == 2'b01) && (off == 2'b11))
                bad = 1'b1;
            if ((f3[1:0] == 2'b10) && (off != 2'b00))
                bad = 1'b1;
        end
        return bad;
    endfunction

    assign req_err = req_illegal(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);
    assign accept  = (state == IDLE) && bus.req_valid;

    // Memory port and response fields come straight from the latched request,
    // so they stay put from ACCESS through CAPTURE and hold in IDLE/RESP.
    assign bus.MEM_ADDR2 = addr_p0;
    assign bus.MEM_DIN2  = wdata_p0;
    assign bus.MEM_SIZE  = funct3_p0[1:0];
    assign bus.MEM_SIGN  = funct3_p0[2];
    assign bus.rsp_err   = err_p0;
    assign bus.rsp_io    = (addr_p0 >= MMIO_BASE);
    assign bus.rsp_rdata = rdata_p1;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and handshake/strobe decode; strobes are gated by RST so a
    // reset cycle can never write or read memory.
    always_comb begin
        state_nxt     = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.MEM_WE2   = 1'b0;
        bus.MEM_RDEN2 = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid)
                    state_nxt = req_err ? RESP : ACCESS;
            end
            ACCESS: begin
                bus.MEM_WE2   = we_p0 && !RST;
                bus.MEM_RDEN2 = !we_p0 && !RST;
                state_nxt     = we_p0 ? RESP : CAPTURE;
            end
            CAPTURE: begin
                state_nxt = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the request on accept; capture memory read data at the end of CAPTURE.
    // rdata is cleared on accept so stores and errors respond with zero.
    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_p0   <= '0;
            wdata_p0  <= '0;
            we_p0     <= 1'b0;
            funct3_p0 <= '0;
            err_p0    <= 1'b0;
            rdata_p1  <= '0;
        end else begin
            if (accept) begin
                addr_p0   <= bus.req_addr;
                wdata_p0  <= bus.req_wdata;
                we_p0     <= bus.req_we;
                funct3_p0 <= bus.req_funct3;
                err_p0    <= req_err;
                rdata_p1  <= '0;
            end
            if (state == CAPTURE)
                rdata_p1 <= bus.MEM_DOUT2;
        end
    end

endmodule

// File: tb/tb_otter_lsu.sv
// Bench for otter_lsu: vector table plus hand sequences for backpressure,
// reset during ACCESS and the no-alignment-check build.
`timescale 1ns/1ps

module tb_otter_lsu;

    localparam logic [31:0] IO_IN = 32'h12345678;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    otter_lsu_if bus ();
    otter_lsu_if bus2 ();

    otter_lsu #(.MMIO_BASE(32'h00010000), .CHECK_ALIGN(1'b1)) dut (
        .CLK(CLK), .RST(RST), .bus(bus)
    );
    otter_lsu #(.MMIO_BASE(32'h00010000), .CHECK_ALIGN(1'b0)) dut_na (
        .CLK(CLK), .RST(RST), .bus(bus2)
    );

    // ---------------- memory model ----------------
    logic [31:0] mem [0:1023] = '{default: 32'h0};

    function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic [1:0] sz,
                                           input logic uns);
        logic [31:0] w;
        logic [31:0] sh;
        logic [1:0]  off;
        off = a[1:0];
        w   = (a >= 32'h00010000) ? IO_IN : mem[a[11:2]];
        sh  = w >> {off, 3'b000};
        case (sz)
            2'd0: return uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'd1: begin
                if (off == 2'd3) return 32'h0;
                return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            end
            2'd2: return (off == 2'd0) ? w : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge CLK) begin
        if (bus.MEM_RDEN2)
            bus.MEM_DOUT2 <= mem_rd(bus.MEM_ADDR2, bus.MEM_SIZE, bus.MEM_SIGN);
        if (bus.MEM_WE2 && (bus.MEM_ADDR2 < 32'h00010000)) begin
            case (bus.MEM_SIZE)
                2'd0: mem[bus.MEM_ADDR2[11:2]][{bus.MEM_ADDR2[1:0], 3'b000} +: 8] <= bus.MEM_DIN2[7:0];
                2'd1: if (bus.MEM_ADDR2[1:0] != 2'd3)
                    mem[bus.MEM_ADDR2[11:2]][{bus.MEM_ADDR2[1:0], 3'b000} +: 16] <= bus.MEM_DIN2[15:0];
                2'd2: if (bus.MEM_ADDR2[1:0] == 2'd0)
                    mem[bus.MEM_ADDR2[11:2]] <= bus.MEM_DIN2;
                default: ;
            endcase
        end
    end

    always @(posedge CLK) begin
        if (bus2.MEM_RDEN2)
            bus2.MEM_DOUT2 <= mem_rd(bus2.MEM_ADDR2, bus2.MEM_SIZE, bus2.MEM_SIGN);
    end

    // ---------------- strobe pulse counters ----------------
    int we_cnt = 0, rd_cnt = 0, both_cnt = 0, rd2_cnt = 0, we2_cnt = 0;
    always @(negedge CLK) begin
        if (bus.MEM_WE2)  we_cnt  <= we_cnt + 1;
        if (bus.MEM_RDEN2) rd_cnt <= rd_cnt + 1;
        if (bus.MEM_WE2 && bus.MEM_RDEN2) both_cnt <= both_cnt + 1;
        if (bus2.MEM_RDEN2) rd2_cnt <= rd2_cnt + 1;
        if (bus2.MEM_WE2)  we2_cnt <= we2_cnt + 1;
    end

    // ---------------- checking ----------------
    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        io;
        int          id;
    } exp_t;
    exp_t sbq[$];

    task automatic pop_check();
        exp_t e;
        if (sbq.size() == 0) begin
            chk("sb_nonempty", 32'(sbq.size()), 32'd1);
            return;
        end
        e = sbq.pop_front();
        chk($sformatf("v%0d_rdata", e.id), bus.rsp_rdata, e.rdata);
        chk($sformatf("v%0d_err", e.id), 32'(bus.rsp_err), 32'(e.err));
        chk($sformatf("v%0d_io", e.id), 32'(bus.rsp_io), 32'(e.io));
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic        io;
        int          lat;
        int          nwe;
        int          nrd;
    } vec_t;

    vec_t vt [18];

    // Wait (bounded) for req_ready at a falling edge, then let the rising edge accept.
    task automatic wait_accept(input string nm);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (bus.req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
        @(posedge CLK);
    endtask

    task automatic do_req(input vec_t v, input int id);
        exp_t        e;
        int          n, we0, rd0;
        logic        ok;
        logic [31:0] a1;
        logic [1:0]  s1;
        logic        g1;
        string       nm;
        nm  = $sformatf("v%0d", id);
        we0 = we_cnt;
        rd0 = rd_cnt;
        a1  = '0;
        s1  = '0;
        g1  = 1'b0;
        bus.req_we     = v.we;
        bus.req_funct3 = v.f3;
        bus.req_addr   = v.addr;
        bus.req_wdata  = v.wdata;
        bus.req_valid  = 1'b1;
        wait_accept(nm);
        e.rdata = v.rdata; e.err = v.err; e.io = v.io; e.id = id;
        sbq.push_back(e);
        #1 bus.req_valid = 1'b0;
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            n++;
            if (n == 1) begin
                a1 = bus.MEM_ADDR2; s1 = bus.MEM_SIZE; g1 = bus.MEM_SIGN;
                if (!v.err) begin
                    chk({nm, "_addr"}, bus.MEM_ADDR2, v.addr);
                    chk({nm, "_size"}, 32'(bus.MEM_SIZE), 32'(v.f3[1:0]));
                end
            end
            if (n == 2 && !v.err && !v.we) begin
                chk({nm, "_cap_addr"}, bus.MEM_ADDR2, a1);
                chk({nm, "_cap_size"}, 32'(bus.MEM_SIZE), 32'(s1));
                chk({nm, "_cap_sign"}, 32'(bus.MEM_SIGN), 32'(g1));
                chk({nm, "_cap_rden"}, 32'(bus.MEM_RDEN2), 32'd0);
            end
            if (bus.rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk({nm, "_latency"}, 32'(n), 32'(v.lat));
        if (ok && bus.rsp_ready) pop_check();
        @(posedge CLK);
        #1;
        chk({nm, "_we_pulses"}, 32'(we_cnt - we0), 32'(v.nwe));
        chk({nm, "_rd_pulses"}, 32'(rd_cnt - rd0), 32'(v.nrd));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n, we0, rd0;
        logic ok;
        exp_t e;

        //           we    f3      addr          wdata         rdata         err   io    lat nwe nrd
        vt[0]  = '{1'b1, 3'b010, 32'h00000100, 32'hDEADBEEF, 32'h00000000, 1'b0, 1'b0, 2, 1, 0};
        vt[1]  = '{1'b0, 3'b010, 32'h00000100, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 3, 0, 1};
        vt[2]  = '{1'b0, 3'b000, 32'h00000103, 32'h0,        32'hFFFFFFDE, 1'b0, 1'b0, 3, 0, 1};
        vt[3]  = '{1'b0, 3'b100, 32'h00000103, 32'h0,        32'h000000DE, 1'b0, 1'b0, 3, 0, 1};
        vt[4]  = '{1'b0, 3'b101, 32'h00000101, 32'h0,        32'h0000ADBE, 1'b0, 1'b0, 3, 0, 1};
        vt[5]  = '{1'b0, 3'b001, 32'h00000102, 32'h0,        32'hFFFFDEAD, 1'b0, 1'b0, 3, 0, 1};
        vt[6]  = '{1'b0, 3'b010, 32'h00000102, 32'h0,        32'h00000000, 1'b1, 1'b0, 1, 0, 0};
        vt[7]  = '{1'b1, 3'b001, 32'h00000103, 32'h00005555, 32'h00000000, 1'b1, 1'b0, 1, 0, 0};
        vt[8]  = '{1'b0, 3'b011, 32'h00000100, 32'h0,        32'h00000000, 1'b1, 1'b0, 1, 0, 0};
        vt[9]  = '{1'b0, 3'b110, 32'h00000100, 32'h0,        32'h00000000, 1'b1, 1'b0, 1, 0, 0};
        vt[10] = '{1'b1, 3'b100, 32'h00000100, 32'h00000011, 32'h00000000, 1'b1, 1'b0, 1, 0, 0};
        vt[11] = '{1'b1, 3'b000, 32'h00000104, 32'hFFFFFFAB, 32'h00000000, 1'b0, 1'b0, 2, 1, 0};
        vt[12] = '{1'b1, 3'b001, 32'h00000106, 32'h00001234, 32'h00000000, 1'b0, 1'b0, 2, 1, 0};
        vt[13] = '{1'b0, 3'b010, 32'h00000104, 32'h0,        32'h123400AB, 1'b0, 1'b0, 3, 0, 1};
        vt[14] = '{1'b0, 3'b000, 32'h00000104, 32'h0,        32'hFFFFFFAB, 1'b0, 1'b0, 3, 0, 1};
        vt[15] = '{1'b1, 3'b010, 32'h00011000, 32'hCAFEF00D, 32'h00000000, 1'b0, 1'b1, 2, 1, 0};
        vt[16] = '{1'b0, 3'b010, 32'h00011000, 32'h0,        32'h12345678, 1'b0, 1'b1, 3, 0, 1};
        vt[17] = '{1'b0, 3'b001, 32'h00011002, 32'h0,        32'h00001234, 1'b0, 1'b1, 3, 0, 1};

        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b1;
        bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_funct3 = '0;
        bus2.req_addr = '0; bus2.req_wdata = '0; bus2.rsp_ready = 1'b1;

        // reset state
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_rsp_io", 32'(bus.rsp_io), 32'd0);
        chk("rst_we", 32'(bus.MEM_WE2), 32'd0);
        chk("rst_rden", 32'(bus.MEM_RDEN2), 32'd0);
        chk("rst_addr", bus.MEM_ADDR2, 32'd0);
        @(posedge CLK);
        #1 RST = 1'b0;

        // table-driven vectors
        for (int i = 0; i < 18; i++)
            do_req(vt[i], i);

        // backpressure: load held in RESP for 5 cycles, second request waiting
        bus.rsp_ready  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h00000100;
        bus.req_valid  = 1'b1;
        wait_accept("bp");
        e.rdata = 32'hDEADBEEF; e.err = 1'b0; e.io = 1'b0; e.id = 100;
        sbq.push_back(e);
        #1 bus.req_valid = 1'b0;
        n = 0; ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            n++;
            if (bus.rsp_valid) begin ok = 1'b1; break; end
        end
        chk("bp_latency", 32'(n), 32'd3);
        @(posedge CLK);
        #1;
        bus.req_addr  = 32'h00000104;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk($sformatf("bp_hold_valid%0d", i), 32'(bus.rsp_valid), 32'd1);
            chk($sformatf("bp_hold_rdata%0d", i), bus.rsp_rdata, 32'hDEADBEEF);
            chk($sformatf("bp_hold_ready%0d", i), 32'(bus.req_ready), 32'd0);
            chk($sformatf("bp_hold_rden%0d", i), 32'(bus.MEM_RDEN2), 32'd0);
        end
        @(posedge CLK);
        #1 bus.rsp_ready = 1'b1;
        @(negedge CLK);
        if (bus.rsp_valid && bus.rsp_ready) pop_check();
        else chk("bp_release_valid", 32'(bus.rsp_valid), 32'd1);
        @(posedge CLK);
        @(negedge CLK);
        chk("bp_idle_ready", 32'(bus.req_ready), 32'd1);
        chk("bp_idle_valid", 32'(bus.rsp_valid), 32'd0);
        @(posedge CLK);
        e.rdata = 32'h123400AB; e.err = 1'b0; e.io = 1'b0; e.id = 101;
        sbq.push_back(e);
        #1 bus.req_valid = 1'b0;
        @(negedge CLK);
        chk("bp_next_rden", 32'(bus.MEM_RDEN2), 32'd1);
        chk("bp_next_addr", bus.MEM_ADDR2, 32'h00000104);
        n = 1; ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.rsp_valid) begin ok = 1'b1; break; end
            @(negedge CLK);
            n++;
        end
        chk("bp_next_latency", 32'(n), 32'd3);
        if (ok) pop_check();
        @(posedge CLK);
        #1;
        chk("bp_sb_drained", 32'(sbq.size()), 32'd0);

        // reset asserted during the ACCESS cycle of a store
        we0 = we_cnt;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h00000200;
        bus.req_wdata  = 32'h55AA55AA;
        bus.req_valid  = 1'b1;
        wait_accept("rst_mid");
        #1 RST = 1'b1;
        bus.req_valid = 1'b0;
        @(negedge CLK);
        chk("rst_mid_we_gated", 32'(bus.MEM_WE2), 32'd0);
        @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("rst_mid_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_mid_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_mid_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_mid_addr", bus.MEM_ADDR2, 32'd0);
        chk("rst_mid_mem", mem[32'h200 >> 2], 32'd0);
        @(posedge CLK);
        #1;
        chk("rst_mid_we_pulses", 32'(we_cnt - we0), 32'd0);

        // no-alignment-check build: misaligned lw goes to memory, returns its data
        rd0 = rd2_cnt;
        bus2.req_we     = 1'b0;
        bus2.req_funct3 = 3'b010;
        bus2.req_addr   = 32'h00000102;
        bus2.req_valid  = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (bus2.req_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("na_accept_timeout", 32'd0, 32'd1);
        @(posedge CLK);
        #1 bus2.req_valid = 1'b0;
        n = 0; ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            n++;
            if (bus2.rsp_valid) begin ok = 1'b1; break; end
        end
        chk("na_latency", 32'(n), 32'd3);
        chk("na_err", 32'(bus2.rsp_err), 32'd0);
        chk("na_rdata", bus2.rsp_rdata, 32'd0);
        @(posedge CLK);
        #1;
        chk("na_rd_pulses", 32'(rd2_cnt - rd0), 32'd1);
        chk("na_we_pulses", 32'(we2_cnt), 32'd0);

        chk("never_both_strobes", 32'(both_cnt), 32'd0);
        chk("sb_final_empty", 32'(sbq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/otter_lsu.md
Name: otter_lsu

Overview:
- Load/store unit for the OTTER RV32I core. It is the initiator on the data port (port 2) of the OTTER memory.
- Accepts one load or store request at a time from the execute stage and checks alignment and funct3.
- Drives MEM_RDEN2/MEM_WE2/MEM_ADDR2/MEM_DIN2/MEM_SIZE/MEM_SIGN and holds them stable across the memory's 1-cycle synchronous read.
- Returns sized, sign-extended load data or store completion through a valid/ready response.

Parameters:
- MMIO_BASE, 32'h00010000, addresses >= this are MMIO; sets rsp_io.
- CHECK_ALIGN, 1, 1 = reject misaligned accesses with rsp_err; 0 = pass all size/offset combinations to memory.

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  synchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  LSU can accept (IDLE only)
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I load/store funct3 ({sign,size[1:0]})
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low bytes used for sb/sh)
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  32  load result (0 for stores/errors)
- rsp_err  out  1  misaligned or illegal funct3; no memory access made
- rsp_io  out  1  access targeted MMIO range
- MEM_RDEN2  out  1  data read enable to memory
- MEM_WE2  out  1  data write enable to memory
- MEM_ADDR2  out  32  data address to memory
- MEM_DIN2  out  32  store data to memory
- MEM_SIZE  out  2  0 byte, 1 half, 2 word
- MEM_SIGN  out  1  1 unsigned, 0 signed
- MEM_DOUT2  in  32  sized and extended data from memory, valid the cycle after MEM_RDEN2

Behaviour:
- States: IDLE, ACCESS, CAPTURE, RESP. Reset: state=IDLE; all registers and outputs 0 except req_ready=1.
- IDLE: req_ready=1. On req_valid:
  - Latch addr, we, funct3, wdata.
  - Compute err: funct3 in {011,110,111}; or funct3 store-illegal (req_we && funct3[2]); or, if CHECK_ALIGN, half with addr[1:0]=11 or word with addr[1:0]!=00.
  - err -> RESP with rsp_err=1. Otherwise -> ACCESS.
- MEM_ADDR2/MEM_DIN2 are always driven from the latched registers. MEM_SIZE=funct3[1:0], MEM_SIGN=funct3[2]. All are stable from ACCESS through CAPTURE and hold their last value in IDLE/RESP.
- ACCESS (1 cycle):
  - MEM_WE2 = we && !RST; MEM_RDEN2 = !we && !RST. These are decoded from state and gated by RST, so neither can fire in a reset cycle.
  - Store -> RESP. Load -> CAPTURE.
- CAPTURE (1 cycle): MEM_RDEN2=0, MEM_WE2=0, address/size/sign held; rsp_rdata <= MEM_DOUT2 at cycle end; -> RESP.
- RESP:
  - rsp_valid=1. rsp_err, rsp_io = (addr >= MMIO_BASE) and rsp_rdata are held stable until rsp_ready.
  - On rsp_valid && rsp_ready -> IDLE, and rsp_valid drops next cycle.
  - No new request is accepted in RESP (req_ready=0).
- Latency, request accepted at edge 0 with rsp_ready tied 1:
  - load: rsp_valid in cycle 3;
  - store: cycle 2;
  - error: cycle 1.
  - Throughput: one request per 4 (load) / 3 (store) / 2 (error) cycles.
- Exactly one MEM_WE2 or MEM_RDEN2 pulse per non-error request; never both; never any pulse for errors.
- Stores to MMIO are not special-cased: the memory converts MEM_WE2 to IO_WR. rsp_io is informational only.
- rsp_rdata=0 for stores and errors.
- RST mid-operation: next edge forces IDLE and clears rsp_valid. Any pending response is dropped. An ACCESS-cycle write coinciding with RST is suppressed.
- req_valid while not in IDLE is ignored; the requester must hold it until req_ready.

Test Plan:
- Store sw addr 0x00000100 data 0xDEADBEEF, then lw 0x100 -> exactly one MEM_WE2 pulse with MEM_SIZE=2. Load rsp_valid 3 cycles after accept, rsp_rdata=0xDEADBEEF, rsp_err=0.
- After above: lb 0x103 -> 0xFFFFFFDE. lbu 0x103 -> 0x000000DE. lhu 0x101 -> 0x0000ADBE. lh 0x102 -> 0xFFFFDEAD. MEM_ADDR2/MEM_SIZE/MEM_SIGN are stable through CAPTURE.
- Errors: lw 0x102; sh 0x103; funct3=011 -> rsp_err=1 one cycle after accept, no RDEN2/WE2 pulse, rsp_rdata=0. With CHECK_ALIGN=0, lw 0x102 issues RDEN2 and returns MEM_DOUT2 (0).
- MMIO: lw 0x00011000 with model IO_IN=0x12345678 -> rsp_rdata=0x12345678, rsp_io=1. sw 0x00011000 -> one MEM_WE2 pulse, rsp_io=1.
- Backpressure: rsp_ready=0 for 5 cycles on a load -> rsp_valid/rsp_rdata held constant, req_ready=0, a new req_valid is ignored. Release -> IDLE next cycle and the new request is accepted.
- Reset in ACCESS of a sw to 0x200 -> no MEM_WE2 observed, memory word 0x200 unchanged, outputs at reset values, req_ready=1 the cycle after.
